// File: rtl/ew_pipe_reg.sv
// EX->WB stage register with a valid/ready handshake and a 2-entry skid buffer.
// Supports synchronous flush, bubble opcode on empty, and optional duplicate-PC write squash.
module ew_pipe_reg #(
    parameter int          XLEN       = 32,
    parameter int          OPW        = 6,
    parameter int          REGW       = 5,
    parameter int          ADDRW      = 26,
    parameter logic [5:0]  NOP_OP     = 6'b110111,
    parameter bit          SQUASH_DUP = 1'b1
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  os_in,
    input  logic [XLEN-1:0]  ot_in,
    input  logic [XLEN-1:0]  imm_dpl_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [OPW-1:0]   op_in,
    input  logic [ADDRW-1:0] addr_in,
    input  logic [REGW-1:0]  wreg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  os_out,
    output logic [XLEN-1:0]  ot_out,
    output logic [XLEN-1:0]  imm_dpl_out,
    output logic [XLEN-1:0]  alu_result_out,
    output logic [OPW-1:0]   op_out,
    output logic [ADDRW-1:0] addr_out,
    output logic [REGW-1:0]  wreg_out
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  os;
        logic [XLEN-1:0]  ot;
        logic [XLEN-1:0]  imm_dpl;
        logic [XLEN-1:0]  alu_result;
        logic [OPW-1:0]   op;
        logic [ADDRW-1:0] addr;
        logic [REGW-1:0]  wreg;
    } bundle_t;

    bundle_t         m_q, m_d, s_q, s_d, in_b;
    logic            m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic            last_pc_vld_q, last_pc_vld_d;
    logic            acc, fire, dup;

    assign in_ready  = ~s_vld_q;
    assign out_valid = m_vld_q;
    assign acc       = in_valid & in_ready;
    assign fire      = m_vld_q & out_ready;
    assign dup       = SQUASH_DUP && last_pc_vld_q && (pc_in == last_pc_q);

    // Squash is decided at accept time so the stored bundle is already final.
    always_comb begin
        in_b.pc         = pc_in;
        in_b.os         = os_in;
        in_b.ot         = ot_in;
        in_b.imm_dpl    = imm_dpl_in;
        in_b.alu_result = alu_result_in;
        in_b.op         = op_in;
        in_b.addr       = addr_in;
        in_b.wreg       = dup ? '0 : wreg_in;
    end

    always_comb begin
        m_d           = m_q;
        s_d           = s_q;
        m_vld_d       = m_vld_q;
        s_vld_d       = s_vld_q;
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        if (flush) begin
            m_vld_d       = 1'b0;
            s_vld_d       = 1'b0;
            last_pc_vld_d = 1'b0;
        end else begin
            if (!m_vld_q) begin
                if (acc) begin
                    m_d     = in_b;
                    m_vld_d = 1'b1;
                end
            end else if (fire) begin
                if (s_vld_q) begin
                    m_d     = s_q;
                    s_vld_d = 1'b0;
                end else if (acc) begin
                    m_d = in_b;
                end else begin
                    m_vld_d = 1'b0;
                end
            end else if (acc) begin
                s_d     = in_b;
                s_vld_d = 1'b1;
            end
            if (acc) begin
                last_pc_d     = pc_in;
                last_pc_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            m_q           <= '0;
            s_q           <= '0;
            m_vld_q       <= 1'b0;
            s_vld_q       <= 1'b0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
        end else begin
            m_q           <= m_d;
            s_q           <= s_d;
            m_vld_q       <= m_vld_d;
            s_vld_q       <= s_vld_d;
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
        end
    end

    assign pc_out         = m_q.pc;
    assign os_out         = m_q.os;
    assign ot_out         = m_q.ot;
    assign imm_dpl_out    = m_q.imm_dpl;
    assign alu_result_out = m_q.alu_result;
    assign addr_out       = m_q.addr;
    // Empty stage presents a bubble so WB never writes regardless of out_valid.
    assign op_out         = m_vld_q ? m_q.op : OPW'(NOP_OP);
    assign wreg_out       = m_vld_q ? m_q.wreg : '0;

endmodule

// File: tb/tb_ew_pipe_reg.sv
// Directed bench for ew_pipe_reg: reset, streaming, backpressure, dup-PC squash, flush.
// A second instance with SQUASH_DUP=0 shares all inputs.
module tb_ew_pipe_reg;

    localparam logic [5:0] NOP = 6'b110111;

    logic        clk = 1'b0;
    logic        rstd, flush, in_valid, out_ready;
    logic [31:0] pc_in, os_in, ot_in, imm_in, alu_in;
    logic [5:0]  op_in;
    logic [25:0] addr_in;
    logic [4:0]  wreg_in;

    logic        in_ready, out_valid, in_ready_n, out_valid_n;
    logic [31:0] pc_out, os_out, ot_out, imm_out, alu_out;
    logic [31:0] pc_out_n, os_out_n, ot_out_n, imm_out_n, alu_out_n;
    logic [5:0]  op_out, op_out_n;
    logic [25:0] addr_out, addr_out_n;
    logic [4:0]  wreg_out, wreg_out_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ew_pipe_reg #(.SQUASH_DUP(1'b1)) dut (
        .clk(clk), .rstd(rstd), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .os_in(os_in), .ot_in(ot_in), .imm_dpl_in(imm_in),
        .alu_result_in(alu_in), .op_in(op_in), .addr_in(addr_in), .wreg_in(wreg_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .os_out(os_out),
        .ot_out(ot_out), .imm_dpl_out(imm_out), .alu_result_out(alu_out),
        .op_out(op_out), .addr_out(addr_out), .wreg_out(wreg_out)
    );

    ew_pipe_reg #(.SQUASH_DUP(1'b0)) dut_nd (
        .clk(clk), .rstd(rstd), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .pc_in(pc_in), .os_in(os_in), .ot_in(ot_in), .imm_dpl_in(imm_in),
        .alu_result_in(alu_in), .op_in(op_in), .addr_in(addr_in), .wreg_in(wreg_in),
        .out_valid(out_valid_n), .out_ready(out_ready), .pc_out(pc_out_n), .os_out(os_out_n),
        .ot_out(ot_out_n), .imm_dpl_out(imm_out_n), .alu_result_out(alu_out_n),
        .op_out(op_out_n), .addr_out(addr_out_n), .wreg_out(wreg_out_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] wr, input logic [5:0] op);
        in_valid = v;
        pc_in    = pc;
        wreg_in  = wr;
        op_in    = op;
        os_in    = pc + 32'h100;
        ot_in    = pc + 32'h200;
        imm_in   = pc + 32'h300;
        alu_in   = pc + 32'h400;
        addr_in  = pc[25:0] + 26'h10;
    endtask

    initial begin
        rstd = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 6'd0);
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_op", {26'b0, op_out}, {26'b0, NOP});
        chk("rst_wreg", {27'b0, wreg_out}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_alu", alu_out, 32'd0);
        rstd = 1'b0;
        tick();

        // Streaming, one per cycle
        out_ready = 1'b1;
        drive(1'b1, 32'h00, 5'd3, 6'd1);
        tick();
        chk("s0_valid", {31'b0, out_valid}, 32'd1);
        chk("s0_pc", pc_out, 32'h00);
        chk("s0_wreg", {27'b0, wreg_out}, 32'd3);
        chk("s0_op", {26'b0, op_out}, 32'd1);
        chk("s0_alu", alu_out, 32'h400);
        chk("s0_rdy", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h04, 5'd4, 6'd2);
        tick();
        chk("s1_pc", pc_out, 32'h04);
        chk("s1_wreg", {27'b0, wreg_out}, 32'd4);
        chk("s1_rdy", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h08, 5'd5, 6'd3);
        tick();
        chk("s2_pc", pc_out, 32'h08);
        chk("s2_wreg", {27'b0, wreg_out}, 32'd5);
        chk("s2_addr", {6'b0, addr_out}, 32'h18);
        drive(1'b0, 32'h08, 5'd5, 6'd3);
        tick();
        chk("s_end_valid", {31'b0, out_valid}, 32'd0);
        chk("s_end_op", {26'b0, op_out}, {26'b0, NOP});
        chk("s_end_hold_pc", pc_out, 32'h08);

        // Backpressure fills M then S
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 5'd1, 6'd4);
        tick();
        chk("bp0_pc", pc_out, 32'h10);
        chk("bp0_rdy", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h14, 5'd2, 6'd5);
        tick();
        chk("bp1_pc", pc_out, 32'h10);
        chk("bp1_rdy", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h18, 5'd6, 6'd6);
        tick();
        chk("bp2_pc_hold", pc_out, 32'h10);
        chk("bp2_op_hold", {26'b0, op_out}, 32'd4);
        chk("bp2_rdy", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp3_pc", pc_out, 32'h14);
        chk("bp3_wreg", {27'b0, wreg_out}, 32'd2);
        chk("bp3_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp4_pc", pc_out, 32'h18);
        chk("bp4_wreg", {27'b0, wreg_out}, 32'd6);
        drive(1'b0, 32'h18, 5'd6, 6'd6);
        tick();
        chk("bp5_valid", {31'b0, out_valid}, 32'd0);

        // Duplicate PC
        drive(1'b1, 32'h20, 5'd7, 6'd7);
        tick();
        chk("dup0_wreg", {27'b0, wreg_out}, 32'd7);
        chk("dup0_wreg_nd", {27'b0, wreg_out_n}, 32'd7);
        tick();
        chk("dup1_valid", {31'b0, out_valid}, 32'd1);
        chk("dup1_wreg", {27'b0, wreg_out}, 32'd0);
        chk("dup1_wreg_nd", {27'b0, wreg_out_n}, 32'd7);
        drive(1'b0, 32'h20, 5'd7, 6'd7);
        tick();

        // Flush with M and S full and input pending
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 5'd8, 6'd8);
        tick();
        drive(1'b1, 32'h34, 5'd9, 6'd9);
        tick();
        chk("fl_pre_rdy", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h38, 5'd10, 6'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_rdy", {31'b0, in_ready}, 32'd1);
        chk("fl_op", {26'b0, op_out}, {26'b0, NOP});
        chk("fl_wreg", {27'b0, wreg_out}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h34, 5'd9, 6'd9);
        tick();
        chk("fl_resend_pc", pc_out, 32'h34);
        chk("fl_resend_wreg", {27'b0, wreg_out}, 32'd9);

        // Flush with a same-cycle fire and a same-cycle accept
        drive(1'b1, 32'h50, 5'd11, 6'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h50, 5'd11, 6'd11);
        chk("ff_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("ff_valid2", {31'b0, out_valid}, 32'd0);
        chk("ff_hold_pc", pc_out, 32'h34);

        // Asynchronous reset mid-stream with M and S full
        out_ready = 1'b0;
        drive(1'b1, 32'h60, 5'd12, 6'd12);
        tick();
        drive(1'b1, 32'h64, 5'd13, 6'd13);
        tick();
        drive(1'b0, 32'h64, 5'd13, 6'd13);
        chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rstd = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_op", {26'b0, op_out}, {26'b0, NOP});
        chk("ar_wreg", {27'b0, wreg_out}, 32'd0);
        chk("ar_pc", pc_out, 32'd0);
        tick();
        rstd = 1'b0;
        tick();
        chk("ar_rdy", {31'b0, in_ready}, 32'd1);
        chk("ar_valid_post", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ew_pipe_reg.md
Name: ew_pipe_reg

Overview:
- Parametrised successor to the fixed EX/WB stage register of the pipeline.
- Carries the same instruction bundle (pc, op, os, ot, addr, imm_dpl, wreg, alu_result) from EX to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble-opcode insertion and switchable duplicate-PC write suppression.
- Sits between the ALU stage and writeback/memory; lets WB stall without dropping or duplicating instructions.

Parameters:
- XLEN, 32, width of pc, os, ot, imm_dpl, alu_result.
- OPW, 6, opcode width.
- REGW, 5, destination register index width.
- ADDRW, 26, jump address field width.
- NOP_OP, 6'b110111, opcode presented when the stage holds no valid instruction.
- SQUASH_DUP, 1, 1 = an instruction whose pc equals the previously accepted pc gets wreg forced to 0.

Ports:
- clk  in  1  clock, rising edge.
- rstd  in  1  reset, asynchronous, active-high (rstd=1 resets).
- flush  in  1  synchronous flush; discards all held and incoming instructions.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- pc_in, os_in, ot_in, imm_dpl_in, alu_result_in  in  XLEN each  bundle fields.
- op_in  in  OPW  opcode.
- addr_in  in  ADDRW  jump address.
- wreg_in  in  REGW  destination register.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- pc_out, os_out, ot_out, imm_dpl_out, alu_result_out  out  XLEN each  held fields.
- op_out  out  OPW  held opcode; NOP_OP when out_valid=0.
- addr_out  out  ADDRW  held address.
- wreg_out  out  REGW  held destination; 0 when out_valid=0.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit. Also last_pc register with last_pc_vld bit.
- Reset (rstd=1, any time, asynchronous):
  - M and S invalid; last_pc_vld=0.
  - in_ready=1, out_valid=0, op_out=NOP_OP, wreg_out=0.
  - All other outputs 0.
- Handshake events:
  - acc = in_valid & in_ready.
  - fire = out_valid & out_ready.
  - out_valid = M.valid.
  - in_valid may be asserted with in_ready=0; the bundle is simply not taken.
- Next-state rules per rising edge, flush=0:
  - M empty, acc: bundle -> M.
  - M full, fire: M <- S if S full (S cleared); else M <- bundle if acc; else M empty.
  - M full, no fire, acc: bundle -> S (S was empty, since in_ready=1).
  - M full, no fire, no acc: hold.
- in_ready next = !S.valid next.
- Throughput and latency:
  - Latency from acc to out_valid is 1 cycle.
  - With out_ready held high, one bundle per cycle.
  - Output fields never change while out_valid=1 and out_ready=0.
- Duplicate-PC squash (SQUASH_DUP=1):
  - On acc, if last_pc_vld and pc_in==last_pc, stored wreg=0; otherwise stored wreg=wreg_in.
  - On every acc, last_pc<=pc_in and last_pc_vld<=1.
  - With SQUASH_DUP=0, wreg is always passed through unchanged.
- Flush (flush=1 at edge):
  - M and S invalid; last_pc_vld=0.
  - Same-cycle input discarded, even if in_valid & in_ready.
  - A same-cycle fire still counts as delivered downstream.
  - in_ready=1 and out_valid=0 on the next cycle.
- Priority: rstd > flush > normal operation.
- Invalid stage: op_out=NOP_OP and wreg_out=0, so WB performs no write even if it ignores out_valid. Other fields hold their last values.

Test Plan:
- Reset: assert rstd mid-stream with M and S full -> same cycle out_valid=0, op_out=6'b110111, wreg_out=0; after release in_ready=1.
- Streaming: out_ready=1; feed pc 0x00,0x04,0x08 with wreg 3,4,5 back-to-back -> outputs appear 1 cycle later in order, no gaps; in_ready stays 1.
- Backpressure: out_ready=0; send pc 0x10 then 0x14 -> M=0x10, S=0x14, in_ready=0; a 0x18 held on the input is not taken; raise out_ready -> outputs 0x10, 0x14, 0x18 in order, no loss or duplication.
- Duplicate PC: accept pc 0x20 wreg 7 twice consecutively -> first wreg_out=7, second wreg_out=0; repeat with SQUASH_DUP=0 -> both 7.
- Flush: with M and S full and in_valid=1, pulse flush -> next cycle out_valid=0, in_ready=1, op_out=NOP_OP; re-sending the previous pc is not squashed.
- Flush + fire: flush with out_ready=1 and M valid -> that M bundle counts as consumed; nothing else emitted.
